meas_sequencer: RTL and testbench
=================================

Name: meas_sequencer

Overview:
- Shares one front-end measurement path (DAC drive plus ADC) between N_REQ requesters, such as secant-style current-reference solvers.
- Per transaction:
  - grants one requester (round-robin);
  - loads the requester's current reference into the DAC;
  - waits a settle interval;
  - runs one ADC conversion (start/done handshake);
  - returns the measured value with a one-cycle done pulse.
- Sits between the control loops and the analog front-end interface.

Parameters:
- BUS_WIDTH, 10, width of the DAC code and of ADC data.
- N_REQ, 2, number of requesters (2..8).
- SETTLE_CYCLES, 16, clk cycles between DAC load and ADC start (>=1).
- TIMEOUT_CYCLES, 255, maximum clk cycles spent waiting for adc_done before abort (>=1).
- AVG_LOG2, 2, log2 of the sample count averaged; used only when MEAS_AVG_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request per requester; held until its done bit pulses.
- i_ref_req  in  N_REQ*BUS_WIDTH  packed per-requester DAC codes; requester k uses bits [k*BUS_WIDTH +: BUS_WIDTH].
- grant  out  N_REQ  one-hot; marks the requester currently being served.
- done  out  N_REQ  one-hot, one-cycle pulse; q_out is valid in that cycle.
- q_out  out  BUS_WIDTH  measured value for the granted requester.
- timeout_err  out  1  high in the done cycle if the transaction aborted on timeout.
- dac_code  out  BUS_WIDTH  DAC code; holds its value between loads.
- dac_load  out  1  one-cycle strobe; dac_code is valid in the same cycle.
- adc_start  out  1  one-cycle conversion request.
- adc_done  in  1  one-cycle pulse from the ADC; adc_data is valid in that cycle.
- adc_data  in  BUS_WIDTH  unsigned conversion result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, takes priority in any state, including mid-transaction):
  - state=IDLE; rr pointer=0;
  - grant, done, q_out, timeout_err, dac_code, dac_load, adc_start, busy all 0;
  - counters and the accumulator cleared;
  - an adc_done arriving after reset is ignored.
- IDLE:
  - if any req bit is set, select the first set bit starting at rr pointer and wrapping modulo N_REQ;
  - assert grant for that bit, latch its i_ref_req slice, go to LOAD.
- LOAD (1 cycle): dac_code=latched code; dac_load=1; clear the settle counter; go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to CONVERT.
- CONVERT (1 cycle): adc_start=1; clear the timeout counter; go to WAIT_ADC.
- WAIT_ADC:
  - on adc_done, capture adc_data and go to RESPOND;
  - if the counter reaches TIMEOUT_CYCLES without adc_done, set the error flag, set q_out=0 and go to RESPOND;
  - if adc_done arrives in the same cycle the timeout expires, adc_done wins (no error).
- RESPOND (1 cycle):
  - done[granted]=1; q_out stays valid through the next IDLE until the next capture;
  - timeout_err equals the error flag in this cycle only;
  - rr pointer = granted index + 1, modulo N_REQ;
  - grant cleared next cycle; go to IDLE.
- req changes while busy:
  - a requester deasserting req mid-transaction does not abort it; the done pulse is still issued;
  - i_ref_req changes after the grant latch have no effect.
- Fairness and latency:
  - a continuously requesting requester waits at most N_REQ-1 transactions.
  - Latency from grant to done with no timeout: 1 (LOAD) + SETTLE_CYCLES + 1 (CONVERT) + ADC latency + 1 (RESPOND).
- Transaction spacing: minimum one IDLE cycle between transactions.
- All arithmetic unsigned; no out-of-range codes are possible.

Optional Feature:
- Macro: MEAS_AVG_EN.
- Defined:
  - after SETTLE, the CONVERT/WAIT_ADC pair repeats 2^AVG_LOG2 times; no re-settle between conversions;
  - samples sum into a BUS_WIDTH+AVG_LOG2-bit accumulator;
  - q_out = accumulator >> AVG_LOG2 (truncating);
  - a timeout on any sample aborts the whole transaction with q_out=0 and timeout_err=1.
- Undefined:
  - one conversion per transaction; AVG_LOG2 is ignored;
  - no accumulator logic is synthesised.

Test Plan:
- Single request: req=01, i_ref0=300, SETTLE=16, ADC returns 512 three cycles after adc_start -> dac_load with code 300; adc_start exactly 17 cycles after dac_load; done=01, q_out=512, timeout_err=0.
- Contention: req=11 held continuously, with ADC responses to requesters 0 and 1 distinguishable -> grants alternate 01,10,01,10; no requester is skipped; each done matches its grant.
- Timeout: adc_done never asserted, TIMEOUT=255 -> done pulses 255 cycles after entering WAIT_ADC; timeout_err=1, q_out=0; the next request is served normally.
- adc_done in the same cycle the timeout expires, adc_data=100 -> q_out=100, timeout_err=0.
- rst asserted during SETTLE, then a stray adc_done -> all outputs 0 the cycle after rst; no done pulse; stray adc_done ignored; next request starts at requester 0.
- MEAS_AVG_EN, AVG_LOG2=2, samples 100,101,102,104 -> exactly 4 adc_start pulses; q_out=101 (sum 407 >> 2).

Source files
------------

// File: rtl/meas_sequencer.sv
// meas_sequencer
//
// Shares one DAC + ADC measurement path between N_REQ requesters.
// Each transaction grants one requester (round-robin), loads its reference
// code into the DAC, waits SETTLE_CYCLES, runs an ADC conversion, and
// returns the result with a one-cycle done pulse.
//
// Optional feature (compile-time macro MEAS_AVG_EN):
//   defined   - the CONVERT/WAIT_ADC pair runs 2^AVG_LOG2 times after one
//               settle interval; q_out is the truncated mean of the samples.
//   undefined - one conversion per transaction, no accumulator.
//
// Ports:
//   clk, rst     - clock (rising edge), synchronous active-high reset
//   req          - level request per requester, held until its done pulse
//   i_ref_req    - packed DAC codes, requester k at [k*BUS_WIDTH +: BUS_WIDTH]
//   grant        - one-hot, requester currently being served
//   done         - one-hot, one-cycle pulse; q_out valid in that cycle
//   q_out        - measured value (0 on timeout); held until next capture
//   timeout_err  - high in the done cycle when the ADC never answered
//   dac_code     - DAC code, held between loads
//   dac_load     - one-cycle strobe, dac_code valid in the same cycle
//   adc_start    - one-cycle conversion request
//   adc_done     - one-cycle ADC completion pulse, adc_data valid with it
//   adc_data     - unsigned conversion result
//   busy         - high whenever the sequencer is not idle
//
// Handshakes: every strobe (dac_load, adc_start, adc_done, done) is a
// single-cycle pulse that is consumed on the clock edge ending that cycle;
// there is no back-pressure on any of them.

module meas_sequencer #(
    parameter int BUS_WIDTH      = 10,
    parameter int N_REQ          = 2,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int AVG_LOG2       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*BUS_WIDTH-1:0] i_ref_req,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           done,
    output logic [BUS_WIDTH-1:0]       q_out,
    output logic                       timeout_err,
    output logic [BUS_WIDTH-1:0]       dac_code,
    output logic                       dac_load,
    output logic                       adc_start,
    input  logic                       adc_done,
    input  logic [BUS_WIDTH-1:0]       adc_data,
    output logic                       busy
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CONVERT,
        S_WAIT_ADC,
        S_RESPOND
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [CNT_W-1:0]   cnt;

    // Unpack the reference codes so selection is a plain array index.
    logic [BUS_WIDTH-1:0] ref_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_ref
        assign ref_arr[g] = i_ref_req[g*BUS_WIDTH +: BUS_WIDTH];
    end

    // Round-robin pick: scan from rr_ptr upward with wrap. The loop runs from
    // the farthest offset down so the nearest set bit is the last to win.
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

`ifdef MEAS_AVG_EN
    localparam int ACC_W = BUS_WIDTH + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [SMP_W-1:0] smp_cnt;

    assign acc_sum = acc + ACC_W'(adc_data);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            gnt_idx     <= '0;
            cnt         <= '0;
            grant       <= '0;
            done        <= '0;
            q_out       <= '0;
            timeout_err <= 1'b0;
            dac_code    <= '0;
            dac_load    <= 1'b0;
            adc_start   <= 1'b0;
            busy        <= 1'b0;
`ifdef MEAS_AVG_EN
            acc         <= '0;
            smp_cnt     <= '0;
`endif
        end else begin
            // Pulse outputs are high for exactly the one state that sets them.
            dac_load    <= 1'b0;
            adc_start   <= 1'b0;
            done        <= '0;
            timeout_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant    <= N_REQ'(1) << pick_idx;
                        gnt_idx  <= pick_idx;
                        // dac_code doubles as the latched reference; later
                        // i_ref_req changes cannot reach it until the next grant.
                        dac_code <= ref_arr[pick_idx];
                        dac_load <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    cnt   <= '0;
`ifdef MEAS_AVG_EN
                    acc     <= '0;
                    smp_cnt <= '0;
`endif
                    state <= S_SETTLE;
                end

                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        adc_start <= 1'b1;
                        state     <= S_CONVERT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_CONVERT: begin
                    cnt   <= '0;
                    state <= S_WAIT_ADC;
                end

                S_WAIT_ADC: begin
                    // adc_done is tested first so a result in the expiring
                    // cycle is still accepted.
                    if (adc_done) begin
`ifdef MEAS_AVG_EN
                        if (smp_cnt == SMP_LAST) begin
                            q_out <= BUS_WIDTH'(acc_sum >> AVG_LOG2);
                            done  <= N_REQ'(1) << gnt_idx;
                            state <= S_RESPOND;
                        end else begin
                            // Next sample: no re-settle, straight back to convert.
                            acc       <= acc_sum;
                            smp_cnt   <= smp_cnt + SMP_W'(1);
                            adc_start <= 1'b1;
                            state     <= S_CONVERT;
                        end
`else
                        q_out <= adc_data;
                        done  <= N_REQ'(1) << gnt_idx;
                        state <= S_RESPOND;
`endif
                    end else if (cnt == TIMEOUT_LAST) begin
                        q_out       <= '0;
                        timeout_err <= 1'b1;
                        done        <= N_REQ'(1) << gnt_idx;
                        state       <= S_RESPOND;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_RESPOND: begin
                    rr_ptr <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + IDX_W'(1);
                    grant  <= '0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_meas_sequencer.sv
// Testbench for meas_sequencer: randomized requesters and ADC, checked by a
// transaction-level reference model (round-robin pick, settle gap, response
// timing, timeout and averaging rules).

module tb_meas_sequencer;

  localparam int BW     = 10;
  localparam int NR     = 2;
  localparam int SETTLE = 16;
  localparam int TMO    = 255;
  localparam int AVG    = 2;
`ifdef MEAS_AVG_EN
  localparam int AVG_SH = AVG;
`else
  localparam int AVG_SH = 0;
`endif
  localparam int NS = 1 << AVG_SH;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic [NR-1:0]      req = '0;
  logic [NR*BW-1:0]   i_ref_req;
  logic [NR-1:0]      grant;
  logic [NR-1:0]      done;
  logic [BW-1:0]      q_out;
  logic               timeout_err;
  logic [BW-1:0]      dac_code;
  logic               dac_load;
  logic               adc_start;
  logic               adc_done = 1'b0;
  logic [BW-1:0]      adc_data = '0;
  logic               busy;

  logic [BW-1:0]      ref_val [NR];

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign i_ref_req[g*BW +: BW] = ref_val[g];
  end

  meas_sequencer #(
    .BUS_WIDTH(BW), .N_REQ(NR), .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TMO), .AVG_LOG2(AVG)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .i_ref_req(i_ref_req),
    .grant(grant), .done(done), .q_out(q_out), .timeout_err(timeout_err),
    .dac_code(dac_code), .dac_load(dac_load), .adc_start(adc_start),
    .adc_done(adc_done), .adc_data(adc_data), .busy(busy)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- stimulus controls (written by main only) ----------------
  int pend [NR];
  int force_lat  = -1;   // >TMO means the ADC never answers
  int force_data = -1;
  bit perturb    = 1'b0;
  bit use_seq    = 1'b0;
  int stray_cnt  = 0;
  int seq_data [4] = '{100, 101, 102, 104};

  // ---------------- reference model + ADC responder ----------------
  int cyc = 0;
  int model_rr = 0;
  int exp_idx = 0;
  int load_cyc = 0;
  int n_starts = 0;
  int sum = 0;
  int resp_cyc = -1;
  int resp_data = 0;
  int exp_done_cyc = -1;
  int exp_q = 0;
  bit exp_err = 1'b0;
  int after_cyc = -1;
  int last_q = 0;
  int stray_seen = 0;
  logic [NR-1:0] prev_req = '0;
  logic [BW-1:0] prev_ref [NR];

  function automatic int pick(input logic [NR-1:0] r, input int rr);
    for (int k = 0; k < NR; k++) begin
      if (r[(rr + k) % NR]) return (rr + k) % NR;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int lat;
    int d;
    cyc++;
    if (rst) begin
      model_rr     = 0;
      resp_cyc     = -1;
      exp_done_cyc = -1;
      after_cyc    = -1;
      last_q       = 0;
      adc_done     = 1'b0;
    end else begin
      if (dac_load) begin
        exp_idx = pick(prev_req, model_rr);
        if (exp_idx < 0) begin
          check("load_without_req", 32'(dac_load), 32'd0);
          exp_idx = 0;
        end else begin
          check("grant", 32'(grant), 32'd1 << exp_idx);
          check("dac_code", 32'(dac_code), 32'(prev_ref[exp_idx]));
          check("busy_load", 32'(busy), 32'd1);
        end
        load_cyc = cyc;
        n_starts = 0;
        sum      = 0;
      end

      if (adc_start) begin
        if (n_starts == 0) check("settle_gap", 32'(cyc - load_cyc), 32'(SETTLE + 1));
        n_starts++;
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(1, 20));
        if (use_seq) d = seq_data[(n_starts - 1) % 4];
        else if (force_data >= 0) d = force_data;
        else d = int'($urandom_range(0, (1 << BW) - 1));
        if (lat > TMO) begin
          resp_cyc     = -1;
          exp_done_cyc = cyc + TMO + 1;
          exp_q        = 0;
          exp_err      = 1'b1;
        end else begin
          resp_cyc  = cyc + lat;
          resp_data = d;
          sum       = sum + d;
          if (n_starts == NS) begin
            exp_done_cyc = resp_cyc + 1;
            exp_q        = sum >> AVG_SH;
            exp_err      = 1'b0;
          end
        end
      end

      if (cyc == exp_done_cyc) begin
        check("done", 32'(done), 32'd1 << exp_idx);
        check("q_out", 32'(q_out), 32'(exp_q));
        check("timeout_err", 32'(timeout_err), 32'(exp_err));
        if (!exp_err) check("n_starts", 32'(n_starts), 32'(NS));
        model_rr     = (exp_idx + 1) % NR;
        last_q       = exp_q;
        exp_done_cyc = -1;
        after_cyc    = cyc + 1;
      end else if (done != '0) begin
        check("spurious_done", 32'(done), 32'd0);
      end

      if (cyc == after_cyc) begin
        check("grant_clear", 32'(grant), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
        check("q_hold", 32'(q_out), 32'(last_q));
      end

      if (cyc == resp_cyc) begin
        adc_done = 1'b1;
        adc_data = BW'(resp_data);
        resp_cyc = -1;
      end else if (stray_cnt != stray_seen) begin
        adc_done = 1'b1;
        adc_data = BW'(777);
        stray_seen++;
      end else begin
        adc_done = 1'b0;
      end
    end
    prev_req = req;
    for (int k = 0; k < NR; k++) prev_ref[k] = ref_val[k];
  end

  // ---------------- driver tasks ----------------
  task automatic refresh_req();
    for (int k = 0; k < NR; k++) req[k] = (pend[k] > 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (done[k] && pend[k] > 0) pend[k]--;
    end
    if (perturb && busy && $urandom_range(0, 3) == 0) begin
      for (int k = 0; k < NR; k++) ref_val[k] = BW'($urandom_range(0, (1 << BW) - 1));
    end
    refresh_req();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    refresh_req();
    while ((req != '0 || busy) && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) check("idle_wait_expired", 32'(n), 32'd0);
    repeat (2) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_q_out"}, 32'(q_out), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_dac_code"}, 32'(dac_code), 32'd0);
    check({tag, "_dac_load"}, 32'(dac_load), 32'd0);
    check({tag, "_adc_start"}, 32'(adc_start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    for (int k = 0; k < NR; k++) begin
      pend[k]    = 0;
      ref_val[k] = '0;
    end
    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Single request, fixed ADC latency and value.
    ref_val[0] = BW'(300);
    force_lat  = 3;
    force_data = 512;
    pend[0]    = 1;
    wait_idle();

    // Continuous contention: grants must alternate.
    force_lat  = -1;
    force_data = -1;
    ref_val[0] = BW'(123);
    ref_val[1] = BW'(456);
    pend[0]    = 4;
    pend[1]    = 4;
    wait_idle();

    // Timeout, then a normal transaction.
    force_lat = 1000;
    pend[1]   = 1;
    wait_idle();
    force_lat = -1;
    pend[0]   = 1;
    wait_idle();

    // adc_done exactly in the expiring cycle, and one cycle before it.
    force_lat  = TMO;
    force_data = 100;
    pend[1]    = 1;
    wait_idle();
    force_lat  = TMO - 1;
    force_data = 55;
    pend[0]    = 1;
    wait_idle();
    force_lat  = -1;
    force_data = -1;

    // Reset during SETTLE, then a stray adc_done.
    pend[0] = 1;
    wait_idle();
    pend[0] = 1;
    refresh_req();
    n = 0;
    while (!busy && n < 100) begin
      tick();
      n++;
    end
    check("reached_busy", 32'(busy), 32'd1);
    repeat (5) tick();
    rst = 1'b1;
    for (int k = 0; k < NR; k++) pend[k] = 0;
    tick();
    rst = 1'b0;
    check_all_zero("midreset");
    stray_cnt++;
    repeat (6) tick();
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_q_out", 32'(q_out), 32'd0);
    ref_val[0] = BW'(11);
    ref_val[1] = BW'(22);
    pend[0]    = 1;
    pend[1]    = 1;
    wait_idle();

    // Randomized rounds with reference codes changing mid-transaction.
    perturb = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NR; k++) begin
        pend[k]    = int'($urandom_range(0, 3));
        ref_val[k] = BW'($urandom_range(0, (1 << BW) - 1));
      end
      wait_idle();
    end
    perturb = 1'b0;

`ifdef MEAS_AVG_EN
    use_seq   = 1'b1;
    force_lat = 2;
    pend[0]   = 1;
    wait_idle();
    use_seq   = 1'b0;
    force_lat = -1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
